// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: instruction ROM port, decoder handshake and status signals.
// The master modport is the fetch sequencer; the slave modport is the ROM/decoder/bus side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               run;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         opcode;
  logic [INSTR_W-5:0] operand;
  logic               stall;
  logic               pc_en;
  logic               do_jump;
  logic               instr_valid;
  logic               exec_strobe;
  logic               halted;

  modport master (
    input  run, imem_rdata, stall, pc_en, do_jump,
    output imem_addr, imem_rd_en, opcode, operand, instr_valid, exec_strobe, halted
  );

  modport slave (
    output run, imem_rdata, stall, pc_en, do_jump,
    input  imem_addr, imem_rd_en, opcode, operand, instr_valid, exec_strobe, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches from a synchronous ROM, hands IR to decode.
// Optional INSTR_COUNT_EN adds a saturating 16-bit executed-instruction counter port.
module fetch_sequencer #(
  parameter int unsigned      ADDR_W   = 8,
  parameter int unsigned      INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef INSTR_COUNT_EN
  output logic [15:0]           instr_count_o,
`endif
  fetch_sequencer_if.master     bus
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StExec, StHalt} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               strobe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign strobe = (state_q == StExec) && !bus.stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle:  if (bus.run) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad: begin
        ir_d    = bus.imem_rdata;
        state_d = StExec;
      end
      StExec: begin
        // Halt wins over jump; decoder inputs only matter on an unstalled EXEC cycle.
        if (strobe) begin
          if (!bus.pc_en) begin
            state_d = StHalt;
          end else begin
            pc_d    = bus.do_jump ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_rd_en  = (state_q == StFetch);
  assign bus.opcode      = ir_q[INSTR_W-1 -: 4];
  assign bus.operand     = ir_q[INSTR_W-5:0];
  assign bus.instr_valid = (state_q == StExec);
  assign bus.exec_strobe = strobe;
  assign bus.halted      = (state_q == StHalt);

`ifdef INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (strobe && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  assign instr_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: ROM and decoder models, hand-computed expected values.
module tb_fetch_sequencer;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [INSTR_W-1:0] rom [256];

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef INSTR_COUNT_EN
    .instr_count_o(instr_count),
`endif
    .bus          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= rom[bus.imem_addr];
  end

  // Decoder model: opcode 15 halts, opcode 11 jumps, everything else advances.
  assign bus.pc_en   = (bus.opcode != 4'hF);
  assign bus.do_jump = (bus.opcode == 4'hB);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.run   = 1'b0;
    bus.stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Steps one full unstalled instruction from FETCH to the next FETCH/HALT.
  task automatic run_instr(input string tag, input logic [3:0] exp_op,
                           input logic [ADDR_W-1:0] exp_next);
    tick();  // LOAD
    tick();  // EXEC
    check_eq({tag, "_opcode"}, 32'(bus.opcode), 32'(exp_op));
    check_eq({tag, "_strobe"}, 32'(bus.exec_strobe), 32'd1);
    tick();
    check_eq({tag, "_next_addr"}, 32'(bus.imem_addr), 32'(exp_next));
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    bus.imem_rdata = '0;
    foreach (rom[i]) rom[i] = 16'h1000;
    rom[8'h01] = 16'hB005;
    rom[8'h05] = 16'hB020;
    rom[8'h21] = 16'hB0FF;

    do_reset();
    check_eq("rst_addr", 32'(bus.imem_addr), 32'h00);
    check_eq("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_strobe", 32'(bus.exec_strobe), 32'd0);
    check_eq("rst_halted", 32'(bus.halted), 32'd0);
    check_eq("rst_opcode", 32'(bus.opcode), 32'd0);
    check_eq("rst_operand", 32'(bus.operand), 32'd0);

    // Basic fetch of ROM[0] and sequential advance.
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    check_eq("t1_fetch_rd_en", 32'(bus.imem_rd_en), 32'd1);
    check_eq("t1_fetch_addr", 32'(bus.imem_addr), 32'h00);
    tick();
    check_eq("t1_load_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    check_eq("t1_exec_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("t1_opcode", 32'(bus.opcode), 32'd1);
    tick();
    check_eq("t1_pc_after", 32'(bus.imem_addr), 32'h01);

    run_instr("jmp5", 4'hB, 8'h05);
    run_instr("jmp20", 4'hB, 8'h20);
    check_eq("t2_strobe_one_cycle", 32'(bus.exec_strobe), 32'd0);

    // Stall four cycles in EXEC of ROM[0x20].
    tick();
    bus.stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_stall_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("t3_stall_strobe", 32'(bus.exec_strobe), 32'd0);
      check_eq("t3_stall_pc", 32'(bus.imem_addr), 32'h20);
      if (i < 3) tick();
    end
    bus.stall = 1'b0;
    #1;
    check_eq("t3_release_strobe", 32'(bus.exec_strobe), 32'd1);
    tick();
    check_eq("t3_after_strobe", 32'(bus.exec_strobe), 32'd0);
    check_eq("t3_next_addr", 32'(bus.imem_addr), 32'h21);

    run_instr("jmpff", 4'hB, 8'hFF);
    run_instr("wrap", 4'h1, 8'h00);
`ifdef INSTR_COUNT_EN
    check_eq("cnt_six", 32'(instr_count), 32'd6);
`endif

    // Halt: opcode 15 at address 0.
    do_reset();
    rom[8'h00] = 16'hF000;
    bus.run = 1'b1;
    tick();
    run_instr("halt", 4'hF, 8'h00);
    for (int i = 0; i < 20; i++) begin
      check_eq("t5_halted", 32'(bus.halted), 32'd1);
      check_eq("t5_rd_en", 32'(bus.imem_rd_en), 32'd0);
      tick();
    end
    check_eq("t5_pc_held", 32'(bus.imem_addr), 32'h00);
`ifdef INSTR_COUNT_EN
    check_eq("cnt_halt", 32'(instr_count), 32'd1);
`endif

    // Reset during a stalled EXEC at pc 0x12.
    do_reset();
    rom[8'h00] = 16'hB012;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    run_instr("jmp12", 4'hB, 8'h12);
    tick();
    bus.stall = 1'b1;
    tick();
    check_eq("t6_stalled_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("t6_stalled_pc", 32'(bus.imem_addr), 32'h12);
    rst_n = 1'b0;
    tick();
    check_eq("t6_rst_addr", 32'(bus.imem_addr), 32'h00);
    check_eq("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("t6_rst_strobe", 32'(bus.exec_strobe), 32'd0);
    check_eq("t6_rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
    check_eq("t6_rst_halted", 32'(bus.halted), 32'd0);
    check_eq("t6_rst_opcode", 32'(bus.opcode), 32'd0);
    check_eq("t6_rst_operand", 32'(bus.operand), 32'd0);
`ifdef INSTR_COUNT_EN
    check_eq("t6_rst_cnt", 32'(instr_count), 32'd0);
`endif
    rst_n     = 1'b1;
    bus.stall = 1'b0;
    tick();
    check_eq("t6_idle_stays", 32'(bus.imem_rd_en), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
